// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap accumulator datapath.
package fir_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_t;

    localparam int          PROD_W  = 32;
    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/rca_32bit.sv
// 32-bit ripple-carry adder built from a chain of full-adder cells.
module rca_32bit
    import fir_pkg::*;
(
    input  logic [PROD_W-1:0] a,
    input  logic [PROD_W-1:0] b,
    input  logic              c,
    output logic [PROD_W-1:0] sum,
    output logic              cout
);

    logic [PROD_W:0] carry_s;

    assign carry_s[0] = c;

    for (genvar i = 0; i < PROD_W; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign cout = carry_s[PROD_W];

endmodule

// File: rtl/fir_tap_accumulator.sv
// Sequential MAC back end: sums NTAPS signed products (or fewer on in_last) into one sample.
// Define FIR_ACC_SAT_EN to clamp the accumulator on signed overflow instead of wrapping.
module fir_tap_accumulator
    import fir_pkg::*;
#(
    parameter  int NTAPS = 16,
    localparam int CNT_W = $clog2(NTAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  tap_cnt
);

    acc_state_t        state_r;
    logic [PROD_W-1:0] acc_r;
    logic [PROD_W-1:0] sum_s;
    logic [PROD_W-1:0] next_acc_s;
    logic              ovf_s;
    logic              accept_s;
    logic              done_s;
    logic              rca_cout_unused_s;

    rca_32bit u_rca (
        .a    (acc_r),
        .b    (in_data),
        .c    (1'b0),
        .sum  (sum_s),
        .cout (rca_cout_unused_s)
    );

    // Signed overflow: both operands share a sign that the sum does not.
    assign ovf_s    = (acc_r[31] == in_data[31]) & (sum_s[31] != acc_r[31]);
    assign in_ready = (state_r == ACC) & ~rst;
    assign accept_s = in_valid & in_ready;
    assign done_s   = in_last | (tap_cnt == CNT_W'(NTAPS - 1));

    // Next accumulator value: clamped or wrapped depending on build.
    always_comb begin
        next_acc_s = sum_s;
`ifdef FIR_ACC_SAT_EN
        if (ovf_s) begin
            next_acc_s = acc_r[31] ? SAT_MIN : SAT_MAX;
        end else begin
            next_acc_s = sum_s;
        end
`else
        next_acc_s = sum_s;
`endif
    end

    // Accumulate/hold state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ACC;
            acc_r     <= 32'h0000_0000;
            tap_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= 32'h0000_0000;
            out_ovf   <= 1'b0;
        end else begin
            case (state_r)
                ACC: begin
                    if (accept_s) begin
                        acc_r   <= next_acc_s;
                        tap_cnt <= tap_cnt + CNT_W'(1);
                        out_ovf <= out_ovf | ovf_s;
                        if (done_s) begin
                            state_r   <= HOLD;
                            out_valid <= 1'b1;
                            out_data  <= next_acc_s;
                        end else begin
                            state_r <= ACC;
                        end
                    end else begin
                        state_r <= ACC;
                    end
                end
                HOLD: begin
                    // Products offered here are not consumed; in_ready is low.
                    if (out_ready) begin
                        state_r   <= ACC;
                        out_valid <= 1'b0;
                        acc_r     <= 32'h0000_0000;
                        tap_cnt   <= '0;
                        out_ovf   <= 1'b0;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r   <= ACC;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Directed bench for fir_tap_accumulator (NTAPS=4) with an expected-sample scoreboard queue.
module tb_fir_tap_accumulator;

    localparam int NTAPS = 4;
    localparam int CNT_W = $clog2(NTAPS);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_ovf;
    logic [CNT_W-1:0] tap_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [32:0] exp_q[$];
    logic [31:0] mdl_acc = 32'h0;
    logic        mdl_ovf = 1'b0;
    int          mdl_cnt = 0;

    logic cnt_en = 1'b0;
    int   low_cnt = 0;

    fir_tap_accumulator #(.NTAPS(NTAPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .tap_cnt   (tap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        mdl_acc = 32'h0;
        mdl_ovf = 1'b0;
        mdl_cnt = 0;
    endtask

    // Reference accumulate of one accepted product; pushes a sample when it closes.
    task automatic mdl_accept(input logic [31:0] d, input logic last);
        logic [31:0] s;
        logic        o;
        s = mdl_acc + d;
        o = (mdl_acc[31] == d[31]) && (s[31] != mdl_acc[31]);
`ifdef FIR_ACC_SAT_EN
        if (o) s = mdl_acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        mdl_acc = s;
        mdl_ovf = mdl_ovf | o;
        mdl_cnt++;
        if (last || mdl_cnt == NTAPS) begin
            exp_q.push_back({mdl_ovf, mdl_acc});
            mdl_clear();
        end
    endtask

    // Offer one product and return #1 after the edge that accepts it.
    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'h0, in_ready}, 32'h1);
        if (in_ready) begin
            @(posedge clk);
            mdl_accept(d, last);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Scoreboard: compare every sample at the point it is handed downstream.
    always @(negedge clk) begin
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_out: observed %h expected none", out_data);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("out_data", out_data, e[31:0]);
                chk("out_ovf", {31'h0, out_ovf}, {31'h0, e[32]});
            end
        end
    end

    // Count cycles in which the block refuses products during the throughput test.
    always @(negedge clk) begin
        if (cnt_en && !in_ready) low_cnt++;
    end

    initial begin
        logic [31:0] exp3;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_ovf", {31'h0, out_ovf}, 32'h0);
        chk("rst_tap_cnt", {30'h0, tap_cnt}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Full sample 1,2,3,4 and output latency
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        chk("t1_tap_cnt3", {30'h0, tap_cnt}, 32'd3);
        chk("t1_no_early_valid", {31'h0, out_valid}, 32'h0);
        send(32'd4, 1'b0);
        chk("t1_latency_valid", {31'h0, out_valid}, 32'h1);
        chk("t1_sum10", out_data, 32'd10);
        chk("t1_ovf0", {31'h0, out_ovf}, 32'h0);

        // Early termination: 5 then -7 with in_last
        send(32'd5, 1'b0);
        chk("t2_tap_cnt1", {30'h0, tap_cnt}, 32'd1);
        send(32'hFFFF_FFF9, 1'b1);
        chk("t2_sum_m2", out_data, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        chk("t2_tap_cnt_clr", {30'h0, tap_cnt}, 32'h0);
        chk("t2_valid_clr", {31'h0, out_valid}, 32'h0);

        // Positive overflow
`ifdef FIR_ACC_SAT_EN
        exp3 = 32'h7FFF_FFFF;
`else
        exp3 = 32'h8000_0010;
`endif
        send(32'h7FFF_FFF0, 1'b0);
        send(32'h0000_0020, 1'b1);
        chk("t3_ovf_data", out_data, exp3);
        chk("t3_ovf_flag", {31'h0, out_ovf}, 32'h1);

        // Negative overflow, and overflow flag sticky past a non-overflowing add
        send(32'h8000_0000, 1'b0);
        send(32'hFFFF_FFFF, 1'b1);
        send(32'h7FFF_FFF0, 1'b0);
        send(32'h0000_0020, 1'b0);
        send(32'hFFFF_FFF0, 1'b1);

        // Backpressure in HOLD with products offered
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'd4, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'h0, out_valid}, 32'h1);
            chk("t4_hold_ready", {31'h0, in_ready}, 32'h0);
            chk("t4_hold_data", out_data, 32'd10);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(32'd1, 1'b1);
        chk("t4_single_last", out_data, 32'd1);

        // Reset mid-sample
        send(32'd1, 1'b0);
        send(32'd1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_clear();
        chk("t5_tap_cnt", {30'h0, tap_cnt}, 32'h0);
        chk("t5_no_valid", {31'h0, out_valid}, 32'h0);
        for (int i = 0; i < 4; i++) send(32'd1, 1'b0);
        chk("t5_sum4", out_data, 32'd4);

        // Reset while a sample is pending
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'd5, 1'b1);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("t5_hold_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("t5_hold_rst_data", out_data, 32'h0);

        // Throughput with out_ready tied high and back-to-back products
        cnt_en = 1'b1;
        for (int s = 0; s < 3; s++) begin
            for (int t = 0; t < NTAPS; t++) send($urandom_range(0, 1000), 1'b0);
        end
        @(posedge clk);
        #1;
        cnt_en = 1'b0;
        chk("t6_ready_low", low_cnt, 32'd3);

        // Drain
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("q_drain", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
